// File: rtl/shift_seq.sv
// Multi-step shift sequencer: applies one single-bit shift/rotate per clock,
// amt times, with the carry fed back through cout between steps.
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic             cin,
  input  logic [2:0]       mode,
  input  logic [AMTW-1:0]  amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMTW-1:0]  count_q, count_d;

  logic             fill_bit;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // One step of the selected operation on the current {data, carry}
  always_comb begin
    if (mode_q[1]) fill_bit = mode_q[0] ? data_q[WIDTH-1] : data_q[0];
    else           fill_bit = carry_q & mode_q[0];

    if (mode_q[2]) begin
      step_data  = {fill_bit, data_q[WIDTH-1:1]};
      step_carry = data_q[0];
    end else begin
      step_data  = {data_q[WIDTH-2:0], fill_bit};
      step_carry = data_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = in;
          carry_d = cin;
          mode_d  = mode;
          count_d = amt;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        count_d = count_q - {{(AMTW-1){1'b0}}, 1'b1};
        if (count_q == {{(AMTW-1){1'b0}}, 1'b1}) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign out  = data_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: driver pushes expected results from a
// closed-form model, monitor pops and compares on each done pulse.
module tb_shift_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_v = 8'h00;
  logic       cin_v = 1'b0;
  logic [2:0] mode_v = 3'd0;
  logic [2:0] amt_v = 3'd0;
  logic       busy, done, cout;
  logic [7:0] out;

  int n_pass = 0;
  int n_total = 0;
  logic [8:0] exp_q[$];

  shift_seq #(.WIDTH(8), .AMTW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in_v), .cin(cin_v),
    .mode(mode_v), .amt(amt_v), .busy(busy), .done(done), .out(out), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Closed-form result {cout,out} of n iterated steps
  function automatic logic [8:0] model(input logic [2:0] m, input logic [7:0] d,
                                       input logic c, input int n);
    longint e;
    logic [8:0] v;
    logic [7:0] o;
    int r;
    if (n == 0) return {c, d};
    v = {c, d};
    case (m)
      3'd0, 3'd2: begin
        e = (longint'(d) << n) | ((m == 3'd2 && d[0]) ? ((longint'(1) << n) - 1) : 64'd0);
        return {e[8], e[7:0]};
      end
      3'd1: begin r = n % 9; v = (v << r) | (v >> (9 - r)); return v; end
      3'd5: begin r = n % 9; v = (v >> r) | (v << (9 - r)); return v; end
      3'd3: begin r = n % 8; o = (d << r) | (d >> (8 - r)); return {o[0], o}; end
      3'd6: begin r = n % 8; o = (d >> r) | (d << (8 - r)); return {o[7], o}; end
      3'd4: begin e = longint'(d) >> (n - 1); return {e[0], e[8:1]}; end
      default: begin e = longint'($signed(d)) >>> (n - 1); return {e[0], e[8:1]}; end
    endcase
  endfunction

  // Monitor: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("result_out", {24'd0, out}, {24'd0, e[7:0]});
        chk("result_cout", {31'd0, cout}, {31'd0, e[8]});
      end
    end
  end

  // Issue one op; optionally pulse an ignored start while busy
  task automatic do_op(input logic [2:0] m, input logic [7:0] d, input logic c,
                       input logic [2:0] n, input bit poke);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    mode_v = m; in_v = d; cin_v = c; amt_v = n; start = 1'b1;
    exp_q.push_back(model(m, d, c, int'(n)));
    @(negedge clk);
    start = 1'b0;
    in_v = $urandom; cin_v = $urandom; mode_v = $urandom; amt_v = $urandom;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && cyc == 1) begin in_v = 8'hFF; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_latency", cyc, int'(n) + 1);
    chk("busy_during_op", {31'd0, busy_ok & busy}, 32'd1);
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    $display("op mode=%0d in=0x%02h cin=%0d amt=%0d -> out=0x%02h cout=%0d cycles=%0d",
             m, d, c, n, out, cout, cyc);
  endtask

  initial begin
    int cyc;
    bit saw_done;
    #1;
    chk("reset_outputs", {21'd0, busy, done, cout, out}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_op(3'b000, 8'h96, 1'b0, 3'd3, 1'b0);
    do_op(3'b110, 8'h81, 1'b0, 3'd1, 1'b0);
    do_op(3'b110, 8'h81, 1'b0, 3'd4, 1'b0);
    do_op(3'b111, 8'h80, 1'b0, 3'd7, 1'b0);
    do_op(3'b001, 8'h80, 1'b1, 3'd2, 1'b0);
    do_op(3'b011, 8'h5A, 1'b1, 3'd0, 1'b0);
    do_op(3'b010, 8'h35, 1'b0, 3'd5, 1'b1);
    do_op(3'b101, 8'h3C, 1'b1, 3'd6, 1'b1);

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));

    // Reset in the middle of a long shift aborts it with no done pulse
    @(negedge clk);
    mode_v = 3'b011; in_v = 8'hA5; cin_v = 1'b1; amt_v = 3'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_abort", {21'd0, busy, done, cout, out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_abort", {31'd0, saw_done}, 32'd0);

    do_op(3'b100, 8'hC3, 1'b0, 3'd2, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-step shift sequencer.
- Applies the single-bit shift/rotate operation, selected by a 3-bit mode, `amt` times in succession: one step per clock, fed back through a carry register.
- Provides variable-distance shifts for the ALU path under a start/busy/done handshake.
- Result and carry-out are held until the next accepted start.

Parameters:
- WIDTH, 8, data width in bits.
- AMTW, 3, width of the shift-amount port; must satisfy 2^AMTW >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- in  input  WIDTH  operand; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- mode  input  3  operation select; captured on accepted start.
- amt  input  AMTW  number of single-bit steps; captured on accepted start.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse when the result is valid.
- out  output  WIDTH  result register.
- cout  output  1  carry-out register.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, out=0, cout=0; internal count=0.
- Single step on data d with carry c, where nb is the fill bit:
  - mode[2]=0 (left): d'={d[W-2:0],nb}, c'=d[W-1].
  - mode[2]=1 (right): d'={nb,d[W-1:1]}, c'=d[0].
- Fill bit nb:
  - mode[1]=0: nb = c & mode[0].
  - mode[1]=1: nb = mode[0] ? d[W-1] : d[0].
- Resulting mode codes:
  - 000 left logical; 001 left through carry; 010 left with LSB fill; 011 rotate left.
  - 100 right logical; 101 right through carry; 110 rotate right; 111 arithmetic right.
- Carry feedback: the step's carry input is the carry register, initialised from captured cin. This makes modes 001/101 (WIDTH+1)-bit rotates through carry when iterated.
- IDLE:
  - start=1: capture in→out, cin→cout, mode, amt→count.
  - Go to DONE if amt=0, else go to SHIFT.
- SHIFT: each cycle apply one step to {out,cout} and decrement count. The step that makes count reach 0 also transitions to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 through DONE and drops in IDLE.
- Latency: done is high in cycle amt+1 after the start edge (amt=0 → the next cycle). Throughput: one operation per amt+2 cycles.
- During SHIFT, out/cout show intermediate values; they are valid only from done onward and hold stable in IDLE.
- start while busy=1 is ignored; no queuing. Inputs are don't-care except in the accepted start cycle.
- amt >= WIDTH is legal; steps continue (e.g. rotate wraps past a full turn).
- Reset asserted mid-SHIFT aborts immediately; outputs return to the reset values above. The first start after reset deassertion is accepted normally.

Test Plan:
- mode=000, in=0x96, amt=3 → out=0xB0, cout=0; done in cycle 4 after start; busy high cycles 1-4.
- mode=110, in=0x81, amt=1 → out=0xC0, cout=1; same in, amt=4 → out=0x18, cout=0.
- mode=111, in=0x80, amt=7 → out=0xFF, cout=0. mode=001, in=0x80, cin=1, amt=2 → out=0x03, cout=0.
- amt=0, in=0x5A, cin=1, any mode → out=0x5A, cout=1, done in the cycle immediately after start.
- start pulsed again while busy (new in=0xFF) → ignored; first result is unchanged. A start issued after done is accepted.
- rst asserted in SHIFT of an amt=7 op → busy=0, done=0, out=0x00, cout=0 asynchronously, before the next clock edge. No done pulse follows.
